led_matrix_scan: RTL and testbench
==================================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of scanned rows (2..32).
REQ-002 SHALL have parameter COLS, default 8, column bits per row (1..32).
REQ-003 SHALL have parameter NFRAMES, default 4, stored pattern slots (power of 2, >=2).
REQ-004 SHALL have parameter DWELL, default 1024, clock cycles each row is driven (>=4).
REQ-005 SHALL have parameter BLANK, default 2, blanking cycles per row (<DWELL; used only with LED_MATRIX_BLANK_EN).
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-008 SHALL have port enable  input  1  scan enable.
REQ-009 SHALL have port sel  input  clog2(NFRAMES)  requested display slot.
REQ-010 SHALL have port wr_en  input  1  pattern-row write strobe.
REQ-011 SHALL have port wr_slot  input  clog2(NFRAMES)  write slot.
REQ-012 SHALL have port wr_row  input  clog2(ROWS)  write row index.
REQ-013 SHALL have port wr_data  input  COLS  write data (bit i = column i lit).
REQ-014 SHALL have port row  output  ROWS  one-hot row drive, registered.
REQ-015 SHALL have port col  output  COLS  column drive, registered.
REQ-016 SHALL have port frame_start  output  1  one-cycle pulse on entry to row 0.

Function
REQ-017 SHALL hold NFRAMES x ROWS words of COLS bits; wr_en writes wr_data to [wr_slot][wr_row] at the clock edge; wr_row >= ROWS is ignored.
REQ-018 SHALL be two-state: IDLE (row=0, col=0, counters cleared) and SCAN; IDLE->SCAN when enable=1; SCAN->IDLE on any cycle with enable=0.
REQ-019 SHALL enter row 0 on the cycle after enable is first sampled high; sel is latched into the active slot at that entry.
REQ-020 SHALL drive each row for exactly DWELL cycles; dwell counter 0..DWELL-1; at DWELL-1 advance row index; ROWS-1 wraps to 0.
REQ-021 SHALL latch sel into the active slot only on each entry to row 0; sel changes mid-frame SHALL NOT alter the current frame.
REQ-022 SHALL load col = mem[active][row_idx] at row entry and hold it for the dwell; writes mid-dwell are visible on the next visit of that row.
REQ-023 SHALL, on a write to the entering address in the same cycle as row entry, display the new wr_data (write-through).
REQ-024 SHALL assert frame_start for exactly one cycle, coincident with row becoming one-hot bit 0.
REQ-025 SHALL keep row and col zero in IDLE; re-enable restarts at row 0 with fresh sel.

Reset
REQ-026 SHALL on rst: row=0, col=0, frame_start=0, state IDLE, row index 0, dwell 0, active slot 0, all pattern memory cleared to 0.
REQ-027 SHALL on rst mid-scan return to the reset state immediately and resume per REQ-019 after release.

Configuration
REQ-028 SHALL, with LED_MATRIX_BLANK_EN defined, force col=0 for the first BLANK cycles of each row dwell (row still asserted), then show pattern data.
REQ-029 SHALL, without LED_MATRIX_BLANK_EN, drive pattern data for the full dwell; BLANK ignored.

Structure
REQ-030 SHALL place default dimension constants and slot/row index typedefs in shared package led_matrix_pkg.
REQ-031 SHALL implement pattern storage as sub-module led_matrix_fb (write port, registered read port, synchronous clear on reset).

Verification (ROWS=8, COLS=8, NFRAMES=4, DWELL=4, BLANK=1)
REQ-032 SHALL cover: rst, load slot0 rows 0..7 = 8'h01<<r, enable=1 -> row walks 01,02..80 every 4 cycles; col matches; frame_start every 32 cycles.
REQ-033 SHALL cover: sel 0->2 at row 3 -> rows 3..7 still slot 0; slot 2 data from next row-0 entry.
REQ-034 SHALL cover: write slot0 row5=8'hAA while row 5 is displayed -> col unchanged this dwell; 8'hAA on next visit.
REQ-035 SHALL cover: enable dropped at row 6 -> next cycle row=0, col=0; re-enable -> row=01 one cycle later, frame_start=1.
REQ-036 SHALL cover: rst asserted mid-row 4 -> row=0, col=0 asynchronously, memory reads 0 after release.
REQ-037 SHALL cover: LED_MATRIX_BLANK_EN defined -> first cycle of each row col=0, remaining 3 cycles pattern; undefined -> 4 pattern cycles.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared dimension defaults, index types and scan state encoding for the LED matrix scanner.
package led_matrix_pkg;
   localparam int DEF_ROWS    = 8;
   localparam int DEF_COLS    = 8;
   localparam int DEF_NFRAMES = 4;
   localparam int DEF_DWELL   = 1024;
   localparam int DEF_BLANK   = 2;

   localparam int DEF_SLOT_W  = $clog2(DEF_NFRAMES);
   localparam int DEF_ROW_W   = $clog2(DEF_ROWS);

   typedef logic [DEF_SLOT_W-1:0] slot_idx_t;
   typedef logic [DEF_ROW_W-1:0]  row_idx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;
endpackage

// File: rtl/led_matrix_fb.sv
// Pattern storage: NFRAMES x ROWS words with one write port and one registered read port.
// Latency: read data appears the cycle after rd_en; a same-edge write to the read address passes through.
// No backpressure; writes are dropped while the post-reset clear is in progress.
module led_matrix_fb #(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int NFRAMES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [$clog2(NFRAMES)-1:0] wr_slot,
   input  logic [$clog2(ROWS)-1:0]    wr_row,
   input  logic [COLS-1:0]            wr_data,
   input  logic                       rd_en,
   input  logic                       rd_clr,
   input  logic [$clog2(NFRAMES)-1:0] rd_slot,
   input  logic [$clog2(ROWS)-1:0]    rd_row,
   output logic [COLS-1:0]            rd_data
);
   logic [COLS-1:0] mem [NFRAMES][ROWS];
   logic            clr_q;
   logic            wr_ok;
   logic            wr_hit;

   // Clear flag is set by reset and held one edge past release, so the array clear stays synchronous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) clr_q <= 1'b1;
      else     clr_q <= 1'b0;
   end

   assign wr_ok  = wr_en && !clr_q && (int'(wr_row) < ROWS);
   assign wr_hit = wr_ok && (wr_slot == rd_slot) && (wr_row == rd_row);

   always_ff @(posedge clk) begin
      if (clr_q) begin
         for (int s = 0; s < NFRAMES; s++)
            for (int r = 0; r < ROWS; r++)
               mem[s][r] <= '0;
      end else if (wr_ok) begin
         mem[wr_slot][wr_row] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rd_data <= '0;
      else if (rd_clr) rd_data <= '0;
      else if (rd_en)  rd_data <= wr_hit ? wr_data : mem[rd_slot][rd_row];
   end
endmodule

// File: rtl/led_matrix_scan.sv
// LED matrix row scanner; define LED_MATRIX_BLANK_EN to blank columns for the first BLANK cycles of each row.
// Latency: row/col/frame_start change one clock after enable is sampled high; each row is held DWELL cycles.
// No backpressure: pattern writes are taken every cycle except the one right after reset release.
module led_matrix_scan
   import led_matrix_pkg::*;
#(
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   parameter int NFRAMES = DEF_NFRAMES,
   parameter int DWELL   = DEF_DWELL,
   parameter int BLANK   = DEF_BLANK
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [$clog2(NFRAMES)-1:0] sel,
   input  logic                       wr_en,
   input  logic [$clog2(NFRAMES)-1:0] wr_slot,
   input  logic [$clog2(ROWS)-1:0]    wr_row,
   input  logic [COLS-1:0]            wr_data,
   output logic [ROWS-1:0]            row,
   output logic [COLS-1:0]            col,
   output logic                       frame_start
);
   localparam int SW = $clog2(NFRAMES);
   localparam int RW = $clog2(ROWS);
   // BLANK is always below DWELL, so this is just clog2(DWELL) with a guard.
   localparam int DW = $clog2((DWELL > BLANK) ? DWELL : BLANK + 1);

   scan_state_t     state_q, state_d;
   logic [RW-1:0]   row_idx_q, row_idx_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [SW-1:0]   active_q, active_d;
   logic [ROWS-1:0] row_q, row_d;
   logic            fs_q, fs_d;
   logic            rd_en, rd_clr;
   logic [SW-1:0]   rd_slot;
   logic [RW-1:0]   rd_row;
   logic [COLS-1:0] pat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         row_idx_q <= '0;
         dwell_q   <= '0;
         active_q  <= '0;
         row_q     <= '0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         dwell_q   <= dwell_d;
         active_q  <= active_d;
         row_q     <= row_d;
         fs_q      <= fs_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      dwell_d   = dwell_q;
      active_d  = active_q;
      row_d     = row_q;
      fs_d      = 1'b0;
      rd_en     = 1'b0;
      rd_clr    = 1'b0;
      rd_slot   = active_q;
      rd_row    = row_idx_q;
      case (state_q)
         ST_IDLE: begin
            row_idx_d = '0;
            dwell_d   = '0;
            row_d     = '0;
            rd_clr    = 1'b1;
            if (enable) begin
               state_d  = ST_SCAN;
               active_d = sel;
               row_d    = {{(ROWS-1){1'b0}}, 1'b1};
               fs_d     = 1'b1;
               rd_en    = 1'b1;
               rd_clr   = 1'b0;
               rd_slot  = sel;
               rd_row   = '0;
            end
         end
         ST_SCAN: begin
            if (!enable) begin
               state_d   = ST_IDLE;
               row_idx_d = '0;
               dwell_d   = '0;
               row_d     = '0;
               rd_clr    = 1'b1;
            end else if (dwell_q == DW'(DWELL - 1)) begin
               dwell_d = '0;
               if (row_idx_q == RW'(ROWS - 1)) begin
                  // Slot selection only takes effect at a frame boundary.
                  row_idx_d = '0;
                  active_d  = sel;
                  fs_d      = 1'b1;
               end else begin
                  row_idx_d = row_idx_q + 1'b1;
               end
               row_d   = {{(ROWS-1){1'b0}}, 1'b1} << row_idx_d;
               rd_en   = 1'b1;
               rd_slot = active_d;
               rd_row  = row_idx_d;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   led_matrix_fb #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .NFRAMES (NFRAMES)
   ) u_fb (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_slot (wr_slot),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_slot (rd_slot),
      .rd_row  (rd_row),
      .rd_data (pat)
   );

`ifdef LED_MATRIX_BLANK_EN
   logic [COLS-1:0] col_q;

   // The pattern word is loaded at row entry and stays put, so it is safe to reveal after blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         col_q <= '0;
      else if ((state_d == ST_SCAN) && (dwell_d >= DW'(BLANK)))
         col_q <= pat;
      else
         col_q <= '0;
   end

   assign col = col_q;
`else
   assign col = pat;
`endif

   assign row         = row_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomized and directed bench for led_matrix_scan against a cycle-count based reference model.
module tb_led_matrix_scan;
   localparam int ROWS    = 8;
   localparam int COLS    = 8;
   localparam int NFRAMES = 4;
   localparam int DWELL   = 4;
   localparam int BLANK   = 1;
   localparam int FRAME   = DWELL * ROWS;
`ifdef LED_MATRIX_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] sel;
   logic       wr_en;
   logic [1:0] wr_slot;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic [7:0] row;
   logic [7:0] col;
   logic       frame_start;

   always #5 clk = ~clk;

   led_matrix_scan #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .NFRAMES (NFRAMES),
      .DWELL   (DWELL),
      .BLANK   (BLANK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .sel         (sel),
      .wr_en       (wr_en),
      .wr_slot     (wr_slot),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .row         (row),
      .col         (col),
      .frame_start (frame_start)
   );

   // Reference: k counts cycles since the scan began; row, blanking and frame boundaries follow from k.
   logic [7:0] mem [NFRAMES][ROWS];
   bit         m_scan;
   int         k;
   int         m_slot;
   logic [7:0] word;
   int         n_checks = 0;
   int         n_pass   = 0;

   function automatic void model_reset();
      m_scan = 1'b0;
      k      = 0;
      m_slot = 0;
      word   = '0;
      for (int s = 0; s < NFRAMES; s++)
         for (int r = 0; r < ROWS; r++)
            mem[s][r] = '0;
   endfunction

   function automatic void model_edge();
      if (wr_en && int'(wr_row) < ROWS) mem[wr_slot][wr_row] = wr_data;
      if (!enable) begin
         m_scan = 1'b0;
      end else if (!m_scan) begin
         m_scan = 1'b1;
         k      = 0;
         m_slot = int'(sel);
         word   = mem[m_slot][0];
      end else begin
         k = k + 1;
         if (k % DWELL == 0) begin
            if ((k / DWELL) % ROWS == 0) m_slot = int'(sel);
            word = mem[m_slot][(k / DWELL) % ROWS];
         end
      end
   endfunction

   function automatic logic [7:0] exp_row();
      logic [7:0] one = 8'h01;
      return m_scan ? (one << ((k / DWELL) % ROWS)) : 8'h00;
   endfunction

   function automatic logic [7:0] exp_col();
      if (!m_scan) return 8'h00;
      if (BLANK_ON && (k % DWELL) < BLANK) return 8'h00;
      return word;
   endfunction

   function automatic logic exp_fs();
      return m_scan && (k % FRAME == 0);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h (k=%0d scan=%0d)", tag, obs, exp, k, m_scan);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      @(negedge clk);
      chk("row", row, exp_row());
      chk("col", col, exp_col());
      chk("frame_start", {7'b0, frame_start}, {7'b0, exp_fs()});
   endtask

   task automatic run_until(input int target);
      int guard = 0;
      while (!(m_scan && (k % FRAME) == target) && guard < 200) begin
         cycle();
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         $error("FAIL run_until: position %0d not reached, observed k=%0d", target, k);
      end
   endtask

   initial begin
      bit wt_done;
      rst = 1'b1; enable = 1'b0; sel = '0;
      wr_en = 1'b0; wr_slot = '0; wr_row = '0; wr_data = '0;
      model_reset();
      #2;
      chk("reset_row", row, 8'h00);
      chk("reset_col", col, 8'h00);
      chk("reset_fs", {7'b0, frame_start}, 8'h00);
      repeat (3) cycle();
      rst = 1'b0;
      cycle();

      // Slot 0 holds a walking bit; other slots get random patterns.
      for (int s = 0; s < NFRAMES; s++) begin
         for (int r = 0; r < ROWS; r++) begin
            wr_en   = 1'b1;
            wr_slot = 2'(s);
            wr_row  = 3'(r);
            wr_data = (s == 0) ? (8'h01 << r) : 8'($urandom);
            cycle();
         end
      end
      wr_en = 1'b0;

      // Two frames from slot 0; a mid-dwell write to row 5 shows only on the next visit.
      enable = 1'b1; sel = 2'd0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         wr_en   = m_scan && (k == 5 * DWELL + 1);
         wr_slot = 2'd0; wr_row = 3'd5; wr_data = 8'hAA;
         cycle();
      end
      wr_en = 1'b0;

      // Slot change mid-frame, then a write-through at the next row-0 entry.
      run_until(3 * DWELL);
      sel = 2'd2;
      wt_done = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         wr_en = !wt_done && m_scan && (k % FRAME == FRAME - 1);
         wr_slot = 2'd2; wr_row = 3'd0; wr_data = 8'h5C;
         if (wr_en) wt_done = 1'b1;
         cycle();
      end
      wr_en = 1'b0;

      // Drop enable at row 6, idle, then restart with a fresh slot.
      run_until(6 * DWELL + 1);
      enable = 1'b0;
      cycle();
      cycle();
      sel = 2'd1; enable = 1'b1;
      repeat (FRAME + 8) cycle();

      // Asynchronous reset in the middle of row 4.
      run_until(4 * DWELL + 1);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_row", row, 8'h00);
      chk("async_rst_col", col, 8'h00);
      cycle();
      cycle();
      rst = 1'b0; sel = 2'd0;
      repeat (FRAME + 8) cycle();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         enable  = ($urandom_range(0, 24) != 0);
         sel     = 2'($urandom);
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_slot = 2'($urandom);
         wr_row  = 3'($urandom);
         wr_data = 8'($urandom);
         cycle();
      end
      wr_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
